pipe_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage RV32I core.
- Produces the stall[5:0] vector and branch_flag consumed by the pc_reg/if_id/id_ex/ex_mem/mem_wb registers.
- Arbitrates per-stage stall requests and accepts branch/jump redirects from EX.
- Holds a registered redirect target until the PC/IF side acknowledges it.

---
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush arbiter and PC redirect holder for the 5-stage RV32I pipeline
// Optional macro PIPE_PERF_CNT_EN adds stall/flush/redirect-wait performance counters.
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  stallreq_if,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  stallreq_mem,
  input  logic                  branch_req_ex,
  input  logic [ADDR_WIDTH-1:0] branch_target_ex,
  input  logic                  pc_redirect_ack,
  output logic [5:0]            stall,
  output logic                  branch_flag,
  output logic                  pc_redirect_valid,
  output logic [ADDR_WIDTH-1:0] pc_redirect_addr,
  output logic                  if_abort
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_stall_mem,
  output logic [CNT_WIDTH-1:0]  perf_stall_ex,
  output logic [CNT_WIDTH-1:0]  perf_stall_id,
  output logic [CNT_WIDTH-1:0]  perf_stall_if,
  output logic [CNT_WIDTH-1:0]  perf_flush,
  output logic [CNT_WIDTH-1:0]  perf_redirect_wait
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic                    abort_q;
  logic                    acc;

  always_comb begin
    stall = 6'b000000;
    if (!rdy_in)           stall = 6'b111111;
    else if (stallreq_mem) stall = 6'b011111;
    else if (stallreq_ex)  stall = 6'b001111;
    else if (stallreq_id)  stall = 6'b000111;
    else if (stallreq_if)  stall = 6'b000011;
  end

  // A branch is only taken when ex_mem can advance; otherwise EX keeps presenting it.
  assign acc         = rdy_in & branch_req_ex & ~stall[3];
  assign branch_flag = acc;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    if (acc) begin
      state_nxt = PEND;
      addr_nxt  = branch_target_ex & ALIGN_MASK;
    end else if (state == PEND && pc_redirect_ack) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      addr_q  <= '0;
      abort_q <= 1'b0;
    end else if (rdy_in) begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      abort_q <= acc & stallreq_if;
    end
  end

  assign pc_redirect_valid = (state == PEND);
  assign pc_redirect_addr  = addr_q;
  assign if_abort          = abort_q;

`ifdef PIPE_PERF_CNT_EN
  logic win_mem, win_ex, win_id, win_if, wait_cyc;

  assign win_mem  = stallreq_mem;
  assign win_ex   = stallreq_ex & ~stallreq_mem;
  assign win_id   = stallreq_id & ~stallreq_ex & ~stallreq_mem;
  assign win_if   = stallreq_if & ~stallreq_id & ~stallreq_ex & ~stallreq_mem;
  assign wait_cyc = (state == PEND) & ~pc_redirect_ack;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_stall_mem     <= '0;
      perf_stall_ex      <= '0;
      perf_stall_id      <= '0;
      perf_stall_if      <= '0;
      perf_flush         <= '0;
      perf_redirect_wait <= '0;
    end else if (rdy_in) begin
      perf_stall_mem     <= perf_stall_mem + CNT_WIDTH'(win_mem);
      perf_stall_ex      <= perf_stall_ex + CNT_WIDTH'(win_ex);
      perf_stall_id      <= perf_stall_id + CNT_WIDTH'(win_id);
      perf_stall_if      <= perf_stall_if + CNT_WIDTH'(win_if);
      perf_flush         <= perf_flush + CNT_WIDTH'(acc);
      perf_redirect_wait <= perf_redirect_wait + CNT_WIDTH'(wait_cyc);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vectors plus a cycle-by-cycle reference model for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0;
  logic        br = 1'b0;
  logic [31:0] target = '0;
  logic        ack = 1'b0;
  logic [5:0]  stall;
  logic        branch_flag, pc_redirect_valid, if_abort;
  logic [31:0] pc_redirect_addr;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] p_mem, p_ex, p_id, p_if, p_flush, p_wait;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .branch_req_ex(br), .branch_target_ex(target), .pc_redirect_ack(ack),
    .stall(stall), .branch_flag(branch_flag), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect_addr(pc_redirect_addr), .if_abort(if_abort)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_mem(p_mem), .perf_stall_ex(p_ex), .perf_stall_id(p_id),
    .perf_stall_if(p_if), .perf_flush(p_flush), .perf_redirect_wait(p_wait)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: what the spec's rules say the outputs must be.
  logic        m_valid = 1'b0, m_abort = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_mem = 0, m_ex = 0, m_id = 0, m_if = 0, m_flush = 0, m_wait = 0;

  function automatic logic [5:0] exp_stall();
    if (!rdy) return 6'h3f;
    if (smem) return 6'h1f;
    if (sex)  return 6'h0f;
    if (sid)  return 6'h07;
    if (sif)  return 6'h03;
    return 6'h00;
  endfunction

  function automatic logic exp_acc();
    return rdy && br && !smem && !sex;
  endfunction

  always @(posedge clk) begin
    logic a;
    a = exp_acc();
    if (!rst) begin
      m_valid = 0; m_addr = 0; m_abort = 0;
      m_mem = 0; m_ex = 0; m_id = 0; m_if = 0; m_flush = 0; m_wait = 0;
    end else if (rdy) begin
      if (m_valid && !ack) m_wait++;
      if (smem) m_mem++;
      else if (sex) m_ex++;
      else if (sid) m_id++;
      else if (sif) m_if++;
      if (a) begin
        m_flush++;
        m_valid = 1;
        m_addr  = {target[31:2], 2'b00};
      end else if (ack) begin
        m_valid = 0;
      end
      m_abort = a && sif;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_stall", stall, exp_stall());
      check("m_flag", branch_flag, exp_acc());
      check("m_valid", pc_redirect_valid, m_valid);
      check("m_addr", pc_redirect_addr, m_addr);
      check("m_abort", if_abort, m_abort);
`ifdef PIPE_PERF_CNT_EN
      check("m_pmem", p_mem, m_mem);
      check("m_pex", p_ex, m_ex);
      check("m_pid", p_id, m_id);
      check("m_pif", p_if, m_if);
      check("m_pflush", p_flush, m_flush);
      check("m_pwait", p_wait, m_wait);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pend();
    br = 0; ack = 1; cyc(); ack = 0;
  endtask

  initial begin
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] flush0;
`endif
    cyc(); cyc();
    check("rst_valid", pc_redirect_valid, 1'b0);
    check("rst_addr", pc_redirect_addr, 32'h0);
    check("rst_abort", if_abort, 1'b0);
    check("rst_stall", stall, 6'h00);
    rst = 1;

    // stall priority
    sif = 1; smem = 1; #1 check("stall_mem_if", stall, 6'b011111);
    smem = 0; #1 check("stall_if", stall, 6'b000011);
    sif = 0; #1 check("stall_none", stall, 6'b000000);
    cyc();

    // basic redirect with held ack
    br = 1; target = 32'h0000_1006; #1 check("br_flag", branch_flag, 1'b1);
    cyc(); br = 0; #1;
    check("br_valid", pc_redirect_valid, 1'b1);
    check("br_addr", pc_redirect_addr, 32'h0000_1004);
    cyc();
    check("br_hold", pc_redirect_addr, 32'h0000_1004);
    ack = 1; cyc(); ack = 0; #1;
    check("br_ack_idle", pc_redirect_valid, 1'b0);

    // branch held behind a mem stall
    br = 1; target = 32'h0000_2000; smem = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("br_blocked", branch_flag, 1'b0);
      cyc();
    end
    smem = 0; #1 check("br_release", branch_flag, 1'b1);
    cyc(); br = 0; #1;
    check("blk_addr", pc_redirect_addr, 32'h0000_2000);
    clear_pend();

    // ack and new branch in the same cycle
`ifdef PIPE_PERF_CNT_EN
    flush0 = p_flush;
`endif
    br = 1; target = 32'h100; cyc();
    target = 32'h200; ack = 1; cyc(); br = 0; ack = 0; #1;
    check("newest_valid", pc_redirect_valid, 1'b1);
    check("newest_addr", pc_redirect_addr, 32'h200);
`ifdef PIPE_PERF_CNT_EN
    check("perf_flush2", p_flush - flush0, 32'd2);
`endif
    clear_pend();

    // if_abort pulse
    br = 1; sif = 1; target = 32'h300; cyc(); br = 0; sif = 0; #1;
    check("abort_pulse", if_abort, 1'b1);
    cyc(); check("abort_end", if_abort, 1'b0);
    br = 1; target = 32'h304; cyc(); br = 0; #1;
    check("abort_none", if_abort, 1'b0);

    // reset during PEND with abort set
    br = 1; sif = 1; target = 32'h308; cyc(); br = 0; sif = 0;
    rst = 0; cyc(); rst = 1; #1;
    check("rstp_valid", pc_redirect_valid, 1'b0);
    check("rstp_addr", pc_redirect_addr, 32'h0);
    check("rstp_abort", if_abort, 1'b0);

    // freeze with rdy low
    br = 1; target = 32'h400; cyc();
    rdy = 0; target = 32'h500; ack = 1; #1;
    check("frz_stall", stall, 6'h3f);
    check("frz_flag", branch_flag, 1'b0);
    cyc(); cyc();
    check("frz_valid", pc_redirect_valid, 1'b1);
    check("frz_addr", pc_redirect_addr, 32'h400);
    rdy = 1; br = 0; ack = 0; cyc();

    // sweep every request pattern with a branch present
    for (int k = 0; k < 16; k++) begin
      {smem, sex, sid, sif} = 4'(k);
      br = k[0]; target = 32'h1000 + 32'(k * 4) + 32'(k % 4);
      ack = k[1];
      cyc();
    end
    {smem, sex, sid, sif} = 4'b0; br = 0; ack = 0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
